// File: rtl/nec_prefetch_if.sv
// Code-fetch bus between the prefetch unit (master) and the memory agent (slave).
// The master holds bus_req/bus_addr stable until the agent returns bus_ack with
// the little-endian word from the even-aligned address in bus_rdata.
interface nec_prefetch_if;
  logic        bus_req;
  logic [19:0] bus_addr;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_ack,
    output bus_rdata
  );
endinterface : nec_prefetch_if

// File: rtl/nec_prefetch.sv
// nec_prefetch: instruction prefetch unit feeding the 8-byte instruction
// prefetch queue (IPQ). Code bytes are fetched at PS:fetch_pc and stored in a
// circular buffer indexed by address bits [2:0]; ipq_len is measured from the
// decoder's current pc. A flush (set_pc) redirects fetch_pc and, if a bus cycle
// is in flight, waits for its ack and throws the data away.
//
// Optional build macro: NEC_PREFETCH_PERF_EN adds perf_fetches, perf_discards
// and perf_full_cycles counters as outputs.
module nec_prefetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] ps,
  input  logic [15:0] decode_pc,
  input  logic        set_pc,
  input  logic [15:0] new_pc,
  output logic [7:0]  ipq [8],
  output logic [3:0]  ipq_len,
  nec_prefetch_if.master bus
`ifdef NEC_PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_discards,
  output logic [31:0] perf_full_cycles
`endif
);

  // Queue depth is fixed: indexing relies on exactly 3 address bits.
  localparam logic [3:0] QUEUE_BYTES = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FETCH      = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } state_e;

  state_e      state_q,    state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        bus_req_q,  bus_req_d;
  logic [19:0] bus_addr_q, bus_addr_d;
  logic [7:0]  ipq_q [8];
  logic [7:0]  ipq_d [8];

  logic [15:0] pc_diff_s;
  logic [3:0]  ipq_len_s;
  logic [3:0]  space_s;
  logic        fetch_ok_s;
  logic [2:0]  wr_idx_s;
  logic        fill_s;
  logic        discard_s;
  logic        unused_pc_diff_hi_s;

  // Occupancy is the distance from the decoder's pc to the next fetch address;
  // the space rule keeps the true distance within 0..8, so 4 bits suffice.
  always_comb begin
    pc_diff_s           = fetch_pc_q - decode_pc;
    ipq_len_s           = pc_diff_s[3:0];
    unused_pc_diff_hi_s = ^pc_diff_s[15:4];
    space_s             = QUEUE_BYTES - ipq_len_s;
    wr_idx_s            = fetch_pc_q[2:0];
    if (fetch_pc_q[0]) begin
      // Odd address fetches a single byte.
      fetch_ok_s = (space_s >= 4'd1);
    end else begin
      // Even address fetches a full word.
      fetch_ok_s = (space_s >= 4'd2);
    end
  end

  // Next-state, bus and queue-write logic; everything holds when ce=0.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    ipq_d      = ipq_q;
    fill_s     = 1'b0;
    discard_s  = 1'b0;

    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (set_pc) begin
            // Redirect only; no request may issue in the flush cycle.
            fetch_pc_d = new_pc;
          end else if (fetch_ok_s) begin
            // Physical address wraps modulo 2^20 by truncation.
            bus_addr_d = {ps, 4'h0} + {4'h0, fetch_pc_q};
            bus_req_d  = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_FETCH: begin
          if (bus.bus_ack) begin
            bus_req_d = 1'b0;
            state_d   = ST_IDLE;
            if (set_pc) begin
              // Ack coincides with a flush: the data belongs to the old stream.
              fetch_pc_d = new_pc;
              discard_s  = 1'b1;
            end else begin
              fill_s = 1'b1;
              if (fetch_pc_q[0]) begin
                ipq_d[wr_idx_s] = bus.bus_rdata[15:8];
                fetch_pc_d      = fetch_pc_q + 16'd1;
              end else begin
                ipq_d[wr_idx_s]        = bus.bus_rdata[7:0];
                ipq_d[wr_idx_s + 3'd1] = bus.bus_rdata[15:8];
                fetch_pc_d             = fetch_pc_q + 16'd2;
              end
            end
          end else if (set_pc) begin
            // A request is never withdrawn; wait for its ack and drop it.
            fetch_pc_d = new_pc;
            state_d    = ST_FLUSH_WAIT;
          end else begin
            state_d = ST_FETCH;
          end
        end

        ST_FLUSH_WAIT: begin
          if (set_pc) begin
            fetch_pc_d = new_pc;
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
          if (bus.bus_ack) begin
            bus_req_d = 1'b0;
            discard_s = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_FLUSH_WAIT;
          end
        end

        default: begin
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, fetch pointer, bus request and queue storage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= 16'h0000;
      bus_req_q  <= 1'b0;
      bus_addr_q <= 20'h00000;
      for (int i = 0; i < 8; i++) begin
        ipq_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      for (int i = 0; i < 8; i++) begin
        ipq_q[i] <= ipq_d[i];
      end
    end
  end

  assign ipq          = ipq_q;
  assign ipq_len      = ipq_len_s;
  assign bus.bus_req  = bus_req_q;
  assign bus.bus_addr = bus_addr_q;

`ifdef NEC_PREFETCH_PERF_EN
  logic [31:0] perf_fetches_q;
  logic [31:0] perf_discards_q;
  logic [31:0] perf_full_cycles_q;
  logic        queue_full_s;

  assign queue_full_s = (ipq_len_s == QUEUE_BYTES);

  // Free-running event counters; wrap naturally on overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetches_q     <= 32'd0;
      perf_discards_q    <= 32'd0;
      perf_full_cycles_q <= 32'd0;
    end else begin
      if (fill_s) begin
        perf_fetches_q <= perf_fetches_q + 32'd1;
      end else begin
        perf_fetches_q <= perf_fetches_q;
      end
      if (discard_s) begin
        perf_discards_q <= perf_discards_q + 32'd1;
      end else begin
        perf_discards_q <= perf_discards_q;
      end
      if (ce && queue_full_s) begin
        perf_full_cycles_q <= perf_full_cycles_q + 32'd1;
      end else begin
        perf_full_cycles_q <= perf_full_cycles_q;
      end
    end
  end

  assign perf_fetches     = perf_fetches_q;
  assign perf_discards    = perf_discards_q;
  assign perf_full_cycles = perf_full_cycles_q;
`else
  logic unused_event_s;
  assign unused_event_s = fill_s ^ discard_s;
`endif

endmodule : nec_prefetch

// File: tb/tb_nec_prefetch.sv
// Directed testbench for nec_prefetch: hand-computed expectations checked with
// immediate assertions after each step.
module tb_nec_prefetch;
  logic        clk;
  logic        reset_n;
  logic        ce;
  logic [15:0] ps;
  logic [15:0] decode_pc;
  logic        set_pc;
  logic [15:0] new_pc;
  logic [7:0]  ipq [8];
  logic [3:0]  ipq_len;
`ifdef NEC_PREFETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_discards;
  logic [31:0] perf_full_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  nec_prefetch_if bus_if ();

  nec_prefetch dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .ps        (ps),
    .decode_pc (decode_pc),
    .set_pc    (set_pc),
    .new_pc    (new_pc),
    .ipq       (ipq),
    .ipq_len   (ipq_len),
    .bus       (bus_if.master)
`ifdef NEC_PREFETCH_PERF_EN
    ,
    .perf_fetches     (perf_fetches),
    .perf_discards    (perf_discards),
    .perf_full_cycles (perf_full_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with space available: request appears after one cycle, then ack.
  task automatic do_fetch(input string tag, input logic [19:0] exp_addr, input logic [15:0] data);
    step();
    check({tag, "_req"}, {31'd0, bus_if.bus_req}, 32'd1);
    check({tag, "_addr"}, {12'd0, bus_if.bus_addr}, {12'd0, exp_addr});
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = data;
    step();
    bus_if.bus_ack   = 1'b0;
    check({tag, "_req_drop"}, {31'd0, bus_if.bus_req}, 32'd0);
  endtask

  initial begin
    reset_n          = 1'b0;
    ce               = 1'b1;
    ps               = 16'h1000;
    decode_pc        = 16'h0100;
    set_pc           = 1'b1;
    new_pc           = 16'h0100;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 16'h0000;
    step();
    step();
    check("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("rst_addr", {12'd0, bus_if.bus_addr}, 32'd0);
    check("rst_len", {28'd0, ipq_len}, 32'd0);
    check("rst_ipq0", {24'd0, ipq[0]}, 32'd0);
    reset_n = 1'b1;

    // Flush cycle to 0x0100: no request issued that cycle.
    step();
    set_pc = 1'b0;
    check("flush_noreq", {31'd0, bus_if.bus_req}, 32'd0);
    check("flush_len", {28'd0, ipq_len}, 32'd0);

    // First fetch at 0x1000:0x0100.
    do_fetch("f1", 20'h10100, 16'hBBAA);
    check("f1_ipq0", {24'd0, ipq[0]}, 32'h0000_00AA);
    check("f1_ipq1", {24'd0, ipq[1]}, 32'h0000_00BB);
    check("f1_len", {28'd0, ipq_len}, 32'd2);

    // Fill to 8 bytes.
    do_fetch("f2", 20'h10102, 16'hDDCC);
    do_fetch("f3", 20'h10104, 16'hFFEE);
    do_fetch("f4", 20'h10106, 16'h1122);
    check("full_len", {28'd0, ipq_len}, 32'd8);
    check("full_ipq6", {24'd0, ipq[6]}, 32'h0000_0022);
    check("full_ipq7", {24'd0, ipq[7]}, 32'h0000_0011);
    step();
    step();
    check("full_noreq", {31'd0, bus_if.bus_req}, 32'd0);

    // One byte consumed: space 1 with even fetch_pc, still no request.
    decode_pc = 16'h0101;
    step();
    step();
    check("sp1_noreq", {31'd0, bus_if.bus_req}, 32'd0);
    check("sp1_len", {28'd0, ipq_len}, 32'd7);

    // Two more consumed: space 3, word fetch resumes.
    decode_pc = 16'h0103;
    do_fetch("f5", 20'h10108, 16'h3344);
    check("f5_ipq0", {24'd0, ipq[0]}, 32'h0000_0044);
    check("f5_len", {28'd0, ipq_len}, 32'd7);

    // Redirect to odd address 0x0203: single byte, then word fetch.
    set_pc    = 1'b1;
    new_pc    = 16'h0203;
    decode_pc = 16'h0203;
    step();
    set_pc = 1'b0;
    check("odd_len0", {28'd0, ipq_len}, 32'd0);
    do_fetch("f6", 20'h10203, 16'h5566);
    check("f6_ipq3", {24'd0, ipq[3]}, 32'h0000_0055);
    check("f6_len", {28'd0, ipq_len}, 32'd1);
    do_fetch("f7", 20'h10204, 16'h7788);
    check("f7_ipq4", {24'd0, ipq[4]}, 32'h0000_0088);
    check("f7_ipq5", {24'd0, ipq[5]}, 32'h0000_0077);
    check("f7_len", {28'd0, ipq_len}, 32'd3);

    // Flush while a fetch is in flight; ack arrives 3 cycles later.
    step();
    check("fw_req", {31'd0, bus_if.bus_req}, 32'd1);
    check("fw_addr", {12'd0, bus_if.bus_addr}, 32'h0001_0206);
    set_pc    = 1'b1;
    new_pc    = 16'h0300;
    decode_pc = 16'h0300;
    ps        = 16'h2000;
    step();
    set_pc = 1'b0;
    check("fw_hold_req", {31'd0, bus_if.bus_req}, 32'd1);
    check("fw_hold_addr", {12'd0, bus_if.bus_addr}, 32'h0001_0206);
    check("fw_len", {28'd0, ipq_len}, 32'd0);
    ps = 16'h1000;
    step();
    step();
    check("fw_hold_addr2", {12'd0, bus_if.bus_addr}, 32'h0001_0206);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 16'h9999;
    step();
    bus_if.bus_ack = 1'b0;
    check("fw_drop_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("fw_drop_ipq6", {24'd0, ipq[6]}, 32'h0000_0022);
    check("fw_drop_len", {28'd0, ipq_len}, 32'd0);
    step();
    check("fw_next_addr", {12'd0, bus_if.bus_addr}, 32'h0001_0300);
    check("fw_next_req", {31'd0, bus_if.bus_req}, 32'd1);

    // Flush coincident with ack: data dropped, next fetch from new_pc.
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 16'hABCD;
    set_pc           = 1'b1;
    new_pc           = 16'h0400;
    decode_pc        = 16'h0400;
    step();
    bus_if.bus_ack = 1'b0;
    set_pc         = 1'b0;
    check("co_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("co_ipq0", {24'd0, ipq[0]}, 32'h0000_0044);
    check("co_len", {28'd0, ipq_len}, 32'd0);
    do_fetch("f8", 20'h10400, 16'h0102);
    check("f8_ipq0", {24'd0, ipq[0]}, 32'h0000_0002);
    check("f8_len", {28'd0, ipq_len}, 32'd2);

    // Segment wrap: 0xF000:0xFFFF then 0xF000:0x0000.
    set_pc    = 1'b1;
    new_pc    = 16'hFFFF;
    decode_pc = 16'hFFFF;
    ps        = 16'hF000;
    step();
    set_pc = 1'b0;
    do_fetch("fw1", 20'hFFFFF, 16'hEE77);
    check("wrap_ipq7", {24'd0, ipq[7]}, 32'h0000_00EE);
    check("wrap_len1", {28'd0, ipq_len}, 32'd1);
    step();
    check("wrap_addr", {12'd0, bus_if.bus_addr}, 32'h000F_0000);

    // ce=0: ack is ignored and everything holds.
    ce               = 1'b0;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 16'h4321;
    step();
    check("ce0_req", {31'd0, bus_if.bus_req}, 32'd1);
    check("ce0_len", {28'd0, ipq_len}, 32'd1);
    check("ce0_ipq0", {24'd0, ipq[0]}, 32'h0000_0002);
    ce = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;
    check("wrap2_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("wrap2_ipq0", {24'd0, ipq[0]}, 32'h0000_0021);
    check("wrap2_ipq1", {24'd0, ipq[1]}, 32'h0000_0043);
    check("wrap2_len", {28'd0, ipq_len}, 32'd3);

`ifdef NEC_PREFETCH_PERF_EN
    check("perf_fetches", perf_fetches, 32'd10);
    check("perf_discards", perf_discards, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule : tb_nec_prefetch
